reg_master: RTL
===============

# reg_master

Register-bus initiator that drives the `sel`/`wr`/`addr`/`wdata` side of the team's register control interface and collects `rdata`. It accepts one command at a time from an upstream valid/ready port, runs a single bus transaction honouring the responder's `ready`, and returns a response on a downstream valid/ready port. It sits between a host-side command source (testbench sequencer, UART bridge, CPU shim) and a register-control responder.

## Interface
- `ADDR_WIDTH`, 8: register address width.
- `DATA_WIDTH`, 16: register data width.
- `TIMEOUT`, 16: maximum cycles `sel` is held waiting for `ready`. Must be ≥1. Used only with the macro under Configuration.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: command accepted when this and `cmd_valid` are both high at an edge.
- `cmd_wr`, input, 1: 1 for a write, 0 for a read.
- `cmd_addr`, input, ADDR_WIDTH: target address.
- `cmd_wdata`, input, DATA_WIDTH: write data. Ignored for reads.
- `sel`, output, 1: bus select to the responder.
- `wr`, output, 1: bus write strobe.
- `addr`, output, ADDR_WIDTH: bus address.
- `wdata`, output, DATA_WIDTH: bus write data.
- `rdata`, input, DATA_WIDTH: responder read data. Registered by the responder and valid the cycle after the accepting edge.
- `ready`, input, 1: responder ready.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: response consumed when this and `rsp_valid` are both high at an edge.
- `rsp_wr`, output, 1: echoes `cmd_wr` of the completed command.
- `rsp_rdata`, output, DATA_WIDTH: read data. Zero for writes and errors.
- `rsp_err`, output, 1: transaction aborted by timeout.

## Operation
- FSM states: IDLE, REQ, RDWAIT, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`: latch `cmd_wr`/`cmd_addr`/`cmd_wdata` into `wr`/`addr`/`wdata`, set `sel`=1, go to REQ.
- **REQ**
  - `sel`=1; `wr`, `addr`, `wdata` held stable.
  - At an edge with `ready`=1 the transfer occurs and `sel`, `wr` clear.
  - Write: go to RESP with `rsp_rdata`=0, `rsp_err`=0.
  - Read: go to RDWAIT.
- **RDWAIT**
  - Lasts exactly 1 cycle, with `sel`=0.
  - At its edge: `rsp_rdata`<=`rdata`, `rsp_err`=0, go to RESP.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` outputs held stable.
  - On `rsp_ready`: go to IDLE.
- `cmd_ready`=1 only in IDLE. At most one outstanding transaction; no command queueing.
- `addr`/`wdata` keep their last values after a transfer. Only `sel`/`wr` return to 0.
- All outputs are registered except `cmd_ready`, which is decoded from state.
- Reset values: state IDLE; `sel`, `wr`, `rsp_valid`, `rsp_wr`, `rsp_err` = 0; `addr`, `wdata`, `rsp_rdata` = 0; `cmd_ready`=1 (state is IDLE).
- Reset mid-operation: asserting `rstn` forces IDLE asynchronously. `sel` drops immediately, the in-flight command is discarded, and no response is produced.

## Timing
Cycle n is the cycle whose closing edge accepts the command.
- Write, `ready` high: `sel` high in n+1; `rsp_valid` from n+2.
- Read, `ready` high: `sel` high in n+1; RDWAIT in n+2; `rsp_valid` with data from n+3.
- Each cycle of `ready`=0 in REQ adds one cycle to both latencies.
- Response back-pressure: RESP holds until `rsp_ready`. A new command can be accepted no earlier than the cycle after the `rsp_ready` handshake.
- Back-to-back throughput: minimum 3 cycles per write, 4 cycles per read.

## Configuration
- Macro: `REG_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter sized to hold TIMEOUT-1 clears on entry to REQ and increments each REQ cycle in which `ready`=0.
  - At an edge with `ready`=0 and counter == TIMEOUT-1, the transaction aborts: `sel`, `wr` clear, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - `sel` is therefore high for at most TIMEOUT cycles.
  - If `ready`=1 on that same edge, the transfer completes normally.
- Not defined: no counter; REQ waits indefinitely and `rsp_err` is tied to 0.

## Test plan
- **Write:** write `addr`=0x10, `wdata`=0xA5A5, `ready` held 1 -> `sel`=1, `wr`=1 for exactly cycle n+1; `rsp_valid` in n+2 with `rsp_wr`=1, `rsp_err`=0, `rsp_rdata`=0x0000.
- **Read:** against a responder model with 0x10 = 0xA5A5, read 0x10 -> `sel`=1, `wr`=0 in n+1; `rsp_valid` in n+3 with `rsp_rdata`=0xA5A5.
- **Wait states:** `ready` low for 3 cycles then high on a write -> `sel` high for 4 cycles; `addr`/`wdata` stable throughout; `rsp_valid` in n+5.
- **Timeout:** with `REG_MASTER_TIMEOUT_EN`, TIMEOUT=4, `ready` stuck 0 -> `sel` high for exactly 4 cycles, then `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0. Without the macro, `sel` is still high after 100 cycles.
- **Response back-pressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> response held stable, `cmd_ready`=0; second command accepted only after the `rsp_ready` handshake.
- **Reset mid-transaction:** assert `rstn`=0 mid-cycle while in REQ -> `sel` falls without a clock edge; after release, `cmd_ready`=1, `rsp_valid`=0, and no stale response appears.

Source files
------------

// File: rtl/reg_master.sv
// -----------------------------------------------------------------------------
// reg_master
//
// Register-bus initiator. Accepts one command at a time on a valid/ready
// command port, runs a single sel/wr/addr/wdata transaction on the register
// bus while honouring the responder's ready, then returns the outcome on a
// valid/ready response port. Only one transaction is ever outstanding.
//
// Parameters
//   ADDR_WIDTH : register address width
//   DATA_WIDTH : register data width
//   TIMEOUT    : maximum cycles sel is held waiting for ready (>= 1); only
//                used when REG_MASTER_TIMEOUT_EN is defined
//
// Configuration macro
//   REG_MASTER_TIMEOUT_EN : when defined, a stalled transfer is aborted after
//                           TIMEOUT cycles of sel and answered with rsp_err=1.
//                           When undefined, REQ waits forever and rsp_err
//                           stays 0.
//
// Ports
//   clk, rstn                            clock, async active-low reset
//   cmd_valid/cmd_ready                  command handshake
//   cmd_wr, cmd_addr, cmd_wdata          command payload
//   sel, wr, addr, wdata                 register bus request (registered)
//   rdata, ready                         register bus response from responder
//   rsp_valid/rsp_ready                  response handshake
//   rsp_wr, rsp_rdata, rsp_err           response payload (registered)
// -----------------------------------------------------------------------------
module reg_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // register bus
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("reg_master: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_wr_q, rsp_wr_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

`ifdef REG_MASTER_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output computation
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef REG_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          sel_d   = 1'b1;
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = S_REQ;
`ifdef REG_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_REQ: begin
        if (ready) begin
          // Transfer happens on this edge; addr/wdata intentionally keep
          // their values, only the strobes drop.
          sel_d     = 1'b0;
          wr_d      = 1'b0;
          rsp_wr_d  = wr_q;
          rsp_err_d = 1'b0;
          if (wr_q) begin
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            // Responder registers rdata, so it is only usable next cycle.
            state_d = S_RDWAIT;
          end
        end
`ifdef REG_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          sel_d       = 1'b0;
          wr_d        = 1'b0;
          rsp_wr_d    = wr_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_RDWAIT: begin
        rsp_rdata_d = rdata;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef REG_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready = (state_q == S_IDLE);
  assign sel       = sel_q;
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
